// File: rtl/ysyx_23060337_inst_encoder_if.sv
// Field-bundle input and encoded-instruction output handshake bundle for the instruction encoder.
// master = producer/consumer side, slave = encoder side.
interface ysyx_23060337_inst_encoder_if #(
  parameter int CNT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_fmt;
  logic [6:0]       in_opcode;
  logic [4:0]       in_rd;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [2:0]       in_funct3;
  logic [6:0]       in_funct7;
  logic [31:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_inst;
  logic             out_err;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output out_ready,
    input  in_ready, out_valid, out_inst, out_err, out_count
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  out_ready,
    output in_ready, out_valid, out_inst, out_err, out_count
  );
endinterface

// File: rtl/ysyx_23060337_inst_encoder.sv
// Packs decoded RV32I fields into instruction words; 2-cycle latency (stage reg + output FIFO).
// Backpressure: in_ready drops only when the stage is held behind a full FIFO that is not popped.
module ysyx_23060337_inst_encoder_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // Extra MSB on each pointer separates full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

module ysyx_23060337_inst_encoder #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 32
) (
  input logic                         clk,
  input logic                         rst_n,
  input logic                         flush,
  ysyx_23060337_inst_encoder_if.slave bus
);
  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } fields_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  fields_t          in_fields;
  fields_t          stg;
  logic             stg_vld;
  logic             accept;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [32:0]      head;
  logic [31:0]      enc_inst;
  logic             enc_err;
  logic             is_shift;
  logic             i_fit;
  logic             b_fit;
  logic             j_fit;
  logic [CNT_W-1:0] cnt;

  assign in_fields = '{fmt: bus.in_fmt, opcode: bus.in_opcode, rd: bus.in_rd,
                       rs1: bus.in_rs1, rs2: bus.in_rs2, funct3: bus.in_funct3,
                       funct7: bus.in_funct7, imm: bus.in_imm};

  assign bus.out_valid = !fifo_empty;
  assign pop           = bus.out_valid && bus.out_ready;
  assign push          = stg_vld && (!fifo_full || pop);
  assign bus.in_ready  = rst_n && !flush && (!stg_vld || push);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_inst  = bus.out_valid ? head[31:0] : 32'h0;
  assign bus.out_err   = bus.out_valid && head[32];
  assign bus.out_count = cnt;

  // Sign-extension checks: every bit above the encodable field must equal the sign bit.
  assign is_shift = (stg.opcode == 7'b0010011) && ((stg.funct3 == 3'b001) || (stg.funct3 == 3'b101));
  assign i_fit    = (&stg.imm[31:11]) || !(|stg.imm[31:11]);
  assign b_fit    = (&stg.imm[31:12]) || !(|stg.imm[31:12]);
  assign j_fit    = (&stg.imm[31:20]) || !(|stg.imm[31:20]);

  always_comb begin
    enc_inst = 32'h0;
    enc_err  = 1'b0;
    case (stg.fmt)
      3'd0: enc_inst = {stg.funct7, stg.rs2, stg.rs1, stg.funct3, stg.rd, stg.opcode};
      3'd1: begin
        if (is_shift) begin
          enc_inst = {stg.funct7, stg.imm[4:0], stg.rs1, stg.funct3, stg.rd, stg.opcode};
          enc_err  = |stg.imm[31:5];
        end else begin
          enc_inst = {stg.imm[11:0], stg.rs1, stg.funct3, stg.rd, stg.opcode};
          enc_err  = !i_fit;
        end
      end
      3'd2: begin
        enc_inst = {stg.imm[11:5], stg.rs2, stg.rs1, stg.funct3, stg.imm[4:0], stg.opcode};
        enc_err  = !i_fit;
      end
      3'd3: begin
        enc_inst = {stg.imm[12], stg.imm[10:5], stg.rs2, stg.rs1, stg.funct3,
                    stg.imm[4:1], stg.imm[11], stg.opcode};
        enc_err  = stg.imm[0] || !b_fit;
      end
      3'd4: begin
        enc_inst = {stg.imm[31:12], stg.rd, stg.opcode};
        enc_err  = |stg.imm[11:0];
      end
      3'd5: begin
        enc_inst = {stg.imm[20], stg.imm[10:1], stg.imm[11], stg.imm[19:12], stg.rd, stg.opcode};
        enc_err  = stg.imm[0] || !j_fit;
      end
      default: begin
        enc_inst = 32'h0;
        enc_err  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_vld <= 1'b0;
      stg     <= '0;
      cnt     <= '0;
    end else if (flush) begin
      stg_vld <= 1'b0;
      cnt     <= '0;
    end else begin
      if (accept) begin
        stg_vld <= 1'b1;
        stg     <= in_fields;
      end else if (push) begin
        stg_vld <= 1'b0;
      end
      if (pop) cnt <= cnt + CNT_ONE;
    end
  end

  ysyx_23060337_inst_encoder_fifo #(
    .W     (33),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flush),
    .push     (push),
    .push_dat ({enc_err, enc_inst}),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_dat (head)
  );
endmodule

// File: tb/tb_ysyx_23060337_inst_encoder.sv
// Scoreboard bench for the instruction encoder: reference encoder/decoder model plus directed and random streams.
`timescale 1ns/1ps
module tb_ysyx_23060337_inst_encoder;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  ysyx_23060337_inst_encoder_if #(.CNT_W(32)) bus ();

  ysyx_23060337_inst_encoder #(
    .FIFO_DEPTH (2),
    .CNT_W      (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          popped = 0;
  bit          rnd_rdy = 1'b0;
  logic [31:0] bnd [12] = '{32'd2047, 32'd2048, -32'd2048, -32'd2049, 32'd4094, 32'd4096,
                            -32'd4096, -32'd4098, 32'h000FFFFE, 32'h00100000, 32'hFFF00000, 32'd31};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
    return (v >> lo) & ((32'h1 << (hi - lo + 1)) - 32'h1);
  endfunction

  function automatic logic [31:0] sx(input logic [31:0] v, input int w);
    logic signed [31:0] t;
    t = v << (32 - w);
    return t >>> (32 - w);
  endfunction

  function automatic bit is_shift(input exp_t b);
    return (b.fmt == 3'd1) && (b.opcode == 7'h13) && ((b.f3 == 3'd1) || (b.f3 == 3'd5));
  endfunction

  // Reference encoder: places each field by shifting, range-checks the immediate as a signed integer.
  function automatic exp_t model(input exp_t b);
    exp_t        e = b;
    logic [31:0] op = 32'(b.opcode);
    logic [31:0] rd = 32'(b.rd);
    logic [31:0] r1 = 32'(b.rs1);
    logic [31:0] r2 = 32'(b.rs2);
    logic [31:0] f3 = 32'(b.f3);
    logic [31:0] f7 = 32'(b.f7);
    logic [31:0] u  = b.imm;
    int          s  = $signed(b.imm);
    logic [31:0] com = op | (f3 << 12) | (r1 << 15);
    e.err = 1'b0;
    case (b.fmt)
      3'd0: e.inst = com | (rd << 7) | (r2 << 20) | (f7 << 25);
      3'd1: begin
        if (is_shift(b)) begin
          e.inst = com | (rd << 7) | (fld(u, 4, 0) << 20) | (f7 << 25);
          e.err  = (u > 32'd31);
        end else begin
          e.inst = com | (rd << 7) | (fld(u, 11, 0) << 20);
          e.err  = (s < -2048) || (s > 2047);
        end
      end
      3'd2: begin
        e.inst = com | (fld(u, 4, 0) << 7) | (r2 << 20) | (fld(u, 11, 5) << 25);
        e.err  = (s < -2048) || (s > 2047);
      end
      3'd3: begin
        e.inst = com | (fld(u, 11, 11) << 7) | (fld(u, 4, 1) << 8) | (r2 << 20)
               | (fld(u, 10, 5) << 25) | (fld(u, 12, 12) << 31);
        e.err  = (u[0] == 1'b1) || (s < -4096) || (s > 4095);
      end
      3'd4: begin
        e.inst = op | (rd << 7) | (u & 32'hFFFFF000);
        e.err  = (u % 4096) != 0;
      end
      3'd5: begin
        e.inst = op | (rd << 7) | (fld(u, 19, 12) << 12) | (fld(u, 11, 11) << 20)
               | (fld(u, 10, 1) << 21) | (fld(u, 20, 20) << 31);
        e.err  = (u[0] == 1'b1) || (s < -(1 << 20)) || (s > (1 << 20) - 1);
      end
      default: begin
        e.inst = 32'h0;
        e.err  = 1'b1;
      end
    endcase
    return e;
  endfunction

  // IDU-style split of an encoded word, compared against the original fields.
  function automatic bit roundtrip_ok(input logic [31:0] i, input exp_t e);
    logic [31:0] dimm;
    bit          ok = (i[6:0] == e.opcode);
    case (e.fmt)
      3'd0: ok = ok && i[11:7] == e.rd && i[14:12] == e.f3 && i[19:15] == e.rs1
                    && i[24:20] == e.rs2 && i[31:25] == e.f7;
      3'd1: begin
        dimm = is_shift(e) ? {27'h0, i[24:20]} : sx({20'h0, i[31:20]}, 12);
        ok = ok && i[11:7] == e.rd && i[14:12] == e.f3 && i[19:15] == e.rs1 && dimm == e.imm;
        if (is_shift(e)) ok = ok && i[31:25] == e.f7;
      end
      3'd2: begin
        dimm = sx({20'h0, i[31:25], i[11:7]}, 12);
        ok = ok && i[14:12] == e.f3 && i[19:15] == e.rs1 && i[24:20] == e.rs2 && dimm == e.imm;
      end
      3'd3: begin
        dimm = sx({19'h0, i[31], i[7], i[30:25], i[11:8], 1'b0}, 13);
        ok = ok && i[14:12] == e.f3 && i[19:15] == e.rs1 && i[24:20] == e.rs2 && dimm == e.imm;
      end
      3'd4: ok = ok && i[11:7] == e.rd && {i[31:12], 12'h0} == e.imm;
      default: begin
        dimm = sx({11'h0, i[31], i[19:12], i[20], i[30:21], 1'b0}, 21);
        ok = ok && i[11:7] == e.rd && dimm == e.imm;
      end
    endcase
    return ok;
  endfunction

  function automatic exp_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm);
    exp_t b;
    b.fmt = fmt; b.opcode = op; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2;
    b.f3 = f3; b.f7 = f7; b.imm = imm; b.inst = 32'h0; b.err = 1'b0;
    return b;
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the bundle.
  task automatic send(input exp_t b);
    int n = 0;
    bus.in_fmt = b.fmt; bus.in_opcode = b.opcode; bus.in_rd = b.rd; bus.in_rs1 = b.rs1;
    bus.in_rs2 = b.rs2; bus.in_funct3 = b.f3; bus.in_funct7 = b.f7; bus.in_imm = b.imm;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        q.push_back(model(b));
        break;
      end
      n++;
      if (n > 500) begin
        errors++;
        $display("FAIL send_timeout actual=stalled required=accept");
        break;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout actual=%0d_left required=0", name, q.size());
    end
    @(negedge clk);
  endtask

  // Holds out_ready low to observe the exact 2-cycle latency, then lets the monitor pop it.
  task automatic directed(input string name, input exp_t b, input logic [31:0] inst, input logic err);
    bus.out_ready = 1'b0;
    send(b);
    @(negedge clk);
    chk({name, "_lat1"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk({name, "_lat2"}, 32'(bus.out_valid), 32'd1);
    chk({name, "_inst"}, bus.out_inst, inst);
    chk({name, "_err"}, 32'(bus.out_err), 32'(err));
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands over an entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (flush) begin
        q.delete();
        popped = 0;
      end else if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output actual=%h required=none", bus.out_inst);
        end else begin
          e = q.pop_front();
          chk("mon_inst", bus.out_inst, e.inst);
          chk("mon_err", 32'(bus.out_err), 32'(e.err));
          chk("mon_count", bus.out_count, 32'(popped));
          if (!e.err) begin
            checks++;
            if (!roundtrip_ok(bus.out_inst, e)) begin
              errors++;
              $display("FAIL roundtrip actual=%h required_fields_fmt%0d_imm=%h", bus.out_inst, e.fmt, e.imm);
            end
          end
          popped++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t b;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_fmt = '0; bus.in_opcode = '0; bus.in_rd = '0; bus.in_rs1 = '0;
    bus.in_rs2 = '0; bus.in_funct3 = '0; bus.in_funct7 = '0; bus.in_imm = '0;

    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_inst", bus.out_inst, 32'd0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    chk("rst_out_count", bus.out_count, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    directed("ex_i",    mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5),        32'h00500093, 1'b0);
    directed("ex_u",    mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000), 32'h123452B7, 1'b0);
    directed("ex_j",    mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8),        32'h008000EF, 1'b0);
    directed("ex_b",    mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'd4),       32'hFE208EE3, 1'b0);
    directed("i_2048",  mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048),     32'h80000093, 1'b1);
    directed("b_imm6",  mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd6),        32'h00208363, 1'b0);
    directed("b_imm3",  mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3),        32'h00208163, 1'b1);
    directed("srai",    mk(3'd1, 7'h13, 5'd3, 5'd4, 5'd0, 3'd5, 7'h20, 32'd7),       32'h40725193, 1'b0);
    directed("fmt6",    mk(3'd6, 7'h33, 5'd3, 5'd4, 5'd5, 3'd1, 7'h01, 32'd0),       32'h00000000, 1'b1);

    // Flush with two entries queued.
    send(mk(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0));
    send(mk(3'd0, 7'h33, 5'd4, 5'd5, 5'd6, 3'd7, 7'h20, 32'd0));
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_out_count", bus.out_count, 32'd0);
    @(posedge clk); #1;

    // Backpressure: stage + 2-deep FIFO hold three bundles, the fourth must stall.
    for (int i = 0; i < 3; i++) send(mk(3'd2, 7'h23, 5'd0, 5'(i), 5'(i + 8), 3'd2, 7'd0, 32'(i * 4)));
    b = mk(3'd2, 7'h23, 5'd0, 5'd3, 5'd11, 3'd2, 7'd0, 32'd12);
    bus.in_fmt = b.fmt; bus.in_opcode = b.opcode; bus.in_rs1 = b.rs1; bus.in_rs2 = b.rs2;
    bus.in_funct3 = b.f3; bus.in_imm = b.imm; bus.in_valid = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_a", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("bp_in_ready_b", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(b);
    drain("bp_drain", 50);
    chk("bp_out_count", bus.out_count, 32'd4);
    @(posedge clk); #1;

    // Random stream with random consumer stalls.
    rnd_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      b.fmt    = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      b.opcode = ($urandom_range(0, 1) == 0) ? 7'h13 : 7'($urandom);
      b.rd = 5'($urandom); b.rs1 = 5'($urandom); b.rs2 = 5'($urandom);
      b.f3 = 3'($urandom); b.f7 = 7'($urandom);
      case ($urandom_range(0, 3))
        0: b.imm = $urandom_range(0, 127) - 64;
        1: b.imm = $urandom;
        2: b.imm = $urandom & 32'hFFFFF000;
        default: b.imm = bnd[$urandom_range(0, 11)];
      endcase
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send(b);
    end
    drain("rnd_drain", 3000);
    rnd_rdy = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("rnd_out_count", bus.out_count, 32'(popped));
    @(posedge clk); #1;

    // Reset mid-stream discards in-flight entries immediately.
    bus.out_ready = 1'b0;
    send(mk(3'd1, 7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'd100));
    send(mk(3'd1, 7'h13, 5'd4, 5'd5, 5'd0, 3'd0, 7'd0, 32'd200));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_out_count", bus.out_count, 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    q.delete();
    popped = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
